// File: rtl/ram_wb_pkg.sv
// Shared definitions for the Wishbone data RAM: FSM state encoding and
// elaboration-time sizing helpers.
package ram_wb_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_wb_array.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and a registered
// read port that can also be cleared to zero (used for error responses).
module ram_wb_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LANES  = 4,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int n = 0; n < LANES; n++) begin
            if (we[n]) begin
                mem[idx][8*n +: 8] <= wdata[8*n +: 8];
            end
        end
    end

    // Read data register: loaded on reads, zeroed on errors, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (rd_clr) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rdata_q <= mem[idx];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_wishbone_sel.sv
// Wishbone classic slave data RAM with byte selects, registered ACK/ERR,
// address range/alignment checking and a post-reset zero-fill sweep.
module ram_wishbone_sel
    import ram_wb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   CLK_I,
    input  logic                   RST_N_I,
    input  logic                   CYC_I,
    input  logic                   STB_I,
    input  logic                   WE_I,
    input  logic [31:0]            ADR_I,
    input  logic [DATA_W/8-1:0]    SEL_I,
    input  logic [DATA_W-1:0]      DAT_I,
    output logic [DATA_W-1:0]      DAT_O,
    output logic                   ACK_O,
    output logic                   ERR_O,
    output logic                   BUSY_O
);

    localparam int          LANES     = lanes(DATA_W);
    localparam int          OFS       = clog2(LANES);
    localparam int          IDX_W     = clog2(DEPTH);
    localparam logic [31:0] ADR_LIMIT = 32'(DEPTH * LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam state_e      RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
    localparam logic        RST_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              req_s;
    logic              adr_bad_s;
    logic [IDX_W-1:0]  idx_s;
    logic [LANES-1:0]  mem_we_s;
    logic [IDX_W-1:0]  mem_idx_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              rd_en_s;
    logic              rd_clr_s;

    assign req_s     = CYC_I & STB_I;
    assign adr_bad_s = (ADR_I >= ADR_LIMIT) || (ADR_I[OFS-1:0] != {OFS{1'b0}});
    assign idx_s     = ADR_I[OFS+IDX_W-1:OFS];

    // Next-state, response and array-control decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        mem_we_s    = {LANES{1'b0}};
        mem_idx_s   = idx_s;
        mem_wdata_s = DAT_I;
        rd_en_s     = 1'b0;
        rd_clr_s    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we_s    = {LANES{1'b1}};
                mem_idx_s   = cnt_q;
                mem_wdata_s = {DATA_W{1'b0}};
                cnt_d       = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_RESP;
                    if (adr_bad_s) begin
                        err_d    = 1'b1;
                        rd_clr_s = 1'b1;
                    end else if (WE_I) begin
                        ack_d    = 1'b1;
                        mem_we_s = SEL_I;
                    end else begin
                        ack_d    = 1'b1;
                        rd_en_s  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // FSM state, sweep counter and registered handshake outputs.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= RST_STATE;
            cnt_q   <= {IDX_W{1'b0}};
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= RST_BUSY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    ram_wb_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (CLK_I),
        .rst_n  (RST_N_I),
        .we     (mem_we_s),
        .idx    (mem_idx_s),
        .wdata  (mem_wdata_s),
        .rd_en  (rd_en_s),
        .rd_clr (rd_clr_s),
        .rdata  (DAT_O)
    );

    assign ACK_O  = ack_q;
    assign ERR_O  = err_q;
    assign BUSY_O = busy_q;

endmodule
